// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue
//   Command-side front end for top_FPU. Commands are buffered in a show-ahead
//   command FIFO, issued to the FPU one per cycle through registered operand
//   outputs, and tracked across the FPU latency. Each result is collected,
//   with its tag, into an in-order show-ahead result FIFO. Issue is
//   credit-gated (inflight + res_count < RES_DEPTH), so a result never finds
//   the result FIFO full.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_op/cmd_a/cmd_b/cmd_tag payload
//   fpu_operation/fpu_a/_b   registered operands to top_FPU
//   fpu_out                  result from top_FPU, valid FPU_LAT edges after operands
//   res_valid/res_ready      result handshake; res_data/res_tag/res_exc head result
//
// Optional feature
//   FPU_ISSUE_DIVZERO_EN: a div whose divisor magnitude is zero returns the quiet
//   NaN 32'h7FC00000 with res_exc=1. When undefined, res_exc is tied to 0.
module fpu_issue_queue #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int FPU_LAT   = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [1:0]       fpu_operation,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  logic [31:0]      fpu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_exc
);
    localparam int CA_W  = $clog2(CMD_DEPTH);
    localparam int CC_W  = CA_W + 1;
    localparam int RA_W  = $clog2(RES_DEPTH);
    localparam int RC_W  = RA_W + 1;
    localparam int CMD_W = 2 + 32 + 32 + TAG_W;
    localparam logic [CC_W-1:0] CMD_FULL    = CC_W'(CMD_DEPTH);
    localparam logic [RC_W:0]   RES_CREDITS = (RC_W + 1)'(RES_DEPTH);

    logic [CA_W-1:0]  cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [CC_W-1:0]  cmd_cnt_q, cmd_cnt_d;
    logic [RA_W-1:0]  res_wr_ptr_q, res_wr_ptr_d, res_rd_ptr_q, res_rd_ptr_d;
    logic [RC_W-1:0]  res_cnt_q, res_cnt_d;
    logic [RC_W-1:0]  inflight_q, inflight_d;
    logic [FPU_LAT:0] trk_v_q, trk_v_d;
    logic [1:0]       fpu_op_q, fpu_op_d;
    logic [31:0]      fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;

    logic [CMD_W-1:0] cmd_mem_q [CMD_DEPTH];
    logic [TAG_W-1:0] trk_tag_q [FPU_LAT+1];
    logic [31:0]      res_data_mem_q [RES_DEPTH];
    logic [TAG_W-1:0] res_tag_mem_q  [RES_DEPTH];

    logic             cmd_push, issue, capture, res_pop;
    logic [RC_W:0]    credit_used;
    logic [1:0]       head_op;
    logic [31:0]      head_a, head_b, cap_data;
    logic [TAG_W-1:0] head_tag;
    logic             cap_exc;

    assign {head_op, head_a, head_b, head_tag} = cmd_mem_q[cmd_rd_ptr_q];

    // cmd_ready is forced low while reset is held and rises as soon as it lifts.
    assign cmd_ready   = rst && (cmd_cnt_q < CMD_FULL);
    assign cmd_push    = cmd_valid && cmd_ready;
    // Credits use registered values only; a same-cycle result pop frees nothing yet.
    assign credit_used = {1'b0, inflight_q} + {1'b0, res_cnt_q};
    assign issue       = (cmd_cnt_q != '0) && (credit_used < RES_CREDITS);
    assign capture     = trk_v_q[FPU_LAT];
    assign res_valid   = (res_cnt_q != '0);
    assign res_pop     = res_valid && res_ready;

`ifdef FPU_ISSUE_DIVZERO_EN
    logic [FPU_LAT:0] trk_exc_q;
    logic             res_exc_mem_q [RES_DEPTH];
    logic             head_exc;

    assign head_exc = (head_op == 2'b11) && (head_b[30:0] == 31'd0);
    assign cap_exc  = trk_exc_q[FPU_LAT];
    assign cap_data = cap_exc ? 32'h7FC0_0000 : fpu_out;
    assign res_exc  = res_valid ? res_exc_mem_q[res_rd_ptr_q] : 1'b0;

    always_ff @(posedge clk) begin
        trk_exc_q[0] <= head_exc;
        for (int i = 1; i <= FPU_LAT; i++) trk_exc_q[i] <= trk_exc_q[i-1];
        if (capture) res_exc_mem_q[res_wr_ptr_q] <= cap_exc;
    end
`else
    assign cap_exc  = 1'b0;
    assign cap_data = fpu_out;
    assign res_exc  = cap_exc;
`endif

    // Outputs are gated to zero when empty so reset shows clean values
    // without clearing the storage arrays.
    assign res_data      = res_valid ? res_data_mem_q[res_rd_ptr_q] : 32'd0;
    assign res_tag       = res_valid ? res_tag_mem_q[res_rd_ptr_q]  : '0;
    assign fpu_operation = fpu_op_q;
    assign fpu_a         = fpu_a_q;
    assign fpu_b         = fpu_b_q;

    always_comb begin
        cmd_wr_ptr_d = cmd_wr_ptr_q;
        cmd_rd_ptr_d = cmd_rd_ptr_q;
        cmd_cnt_d    = cmd_cnt_q;
        res_wr_ptr_d = res_wr_ptr_q;
        res_rd_ptr_d = res_rd_ptr_q;
        res_cnt_d    = res_cnt_q;
        inflight_d   = inflight_q;
        fpu_op_d     = fpu_op_q;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
        trk_v_d      = '0;

        if (cmd_push) cmd_wr_ptr_d = cmd_wr_ptr_q + 1'b1;
        if (issue)    cmd_rd_ptr_d = cmd_rd_ptr_q + 1'b1;
        case ({cmd_push, issue})
            2'b10:   cmd_cnt_d = cmd_cnt_q + 1'b1;
            2'b01:   cmd_cnt_d = cmd_cnt_q - 1'b1;
            default: cmd_cnt_d = cmd_cnt_q;
        endcase

        // Issue stage: load operands, start tracking.
        if (issue) begin
            fpu_op_d = head_op;
            fpu_a_d  = head_a;
            fpu_b_d  = head_b;
        end
        trk_v_d[0] = issue;
        for (int i = 1; i <= FPU_LAT; i++) trk_v_d[i] = trk_v_q[i-1];

        case ({issue, capture})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        // Capture stage: result enters the result FIFO.
        if (capture) res_wr_ptr_d = res_wr_ptr_q + 1'b1;
        if (res_pop) res_rd_ptr_d = res_rd_ptr_q + 1'b1;
        case ({capture, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + 1'b1;
            2'b01:   res_cnt_d = res_cnt_q - 1'b1;
            default: res_cnt_d = res_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_cnt_q    <= '0;
            res_wr_ptr_q <= '0;
            res_rd_ptr_q <= '0;
            res_cnt_q    <= '0;
            inflight_q   <= '0;
            trk_v_q      <= '0;
            fpu_op_q     <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
        end else begin
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            cmd_cnt_q    <= cmd_cnt_d;
            res_wr_ptr_q <= res_wr_ptr_d;
            res_rd_ptr_q <= res_rd_ptr_d;
            res_cnt_q    <= res_cnt_d;
            inflight_q   <= inflight_d;
            trk_v_q      <= trk_v_d;
            fpu_op_q     <= fpu_op_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
        end
    end

    // Storage and tag shift register: data only, qualified by the counts and
    // tracking valid bits, so no reset is needed.
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wr_ptr_q] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
        trk_tag_q[0] <= head_tag;
        for (int i = 1; i <= FPU_LAT; i++) trk_tag_q[i] <= trk_tag_q[i-1];
        if (capture) begin
            res_data_mem_q[res_wr_ptr_q] <= cap_data;
            res_tag_mem_q[res_wr_ptr_q]  <= trk_tag_q[FPU_LAT];
        end
    end

endmodule

// File: tb/tb_fpu_issue_queue.sv
module tb_fpu_issue_queue;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_a, cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [1:0]       fpu_operation;
    logic [31:0]      fpu_a, fpu_b, fpu_out;
    logic             res_valid, res_ready, res_exc;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;

    always #5 clk = ~clk;

    fpu_issue_queue #(.CMD_DEPTH(4), .RES_DEPTH(4), .FPU_LAT(1), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .fpu_operation(fpu_operation), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_out(fpu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_exc(res_exc)
    );

    // Stand-in for top_FPU: exact IEEE results for the directed operand sets,
    // an arbitrary deterministic mix otherwise. One-edge latency.
    function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b10 && a == 32'h41A00000 && b == 32'h40000000) return 32'h42200000;
        if (op == 2'b01 && a == 32'h41900000 && b == 32'h40400000) return 32'h41700000;
        if (op == 2'b00 && a == 32'hC1C80000 && b == 32'h41880000) return 32'hC1000000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    always @(posedge clk) fpu_out <= fpu_fn(fpu_operation, fpu_a, fpu_b);

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             exc;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [TAG_W-1:0] tag);
        res_t r;
        r.data = fpu_fn(op, a, b);
        r.tag  = tag;
        r.exc  = 1'b0;
`ifdef FPU_ISSUE_DIVZERO_EN
        if (op == 2'b11 && b[30:0] == 31'd0) begin
            r.data = 32'h7FC00000;
            r.exc  = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Records handshakes that complete at the coming edge, then advances one cycle.
    task automatic step();
        if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_op, cmd_a, cmd_b, cmd_tag));
        if (res_valid && res_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL res_spurious: observed tag %0d expected no result", res_tag);
            end
            if (exp_q.size() > 0) begin
                res_t e;
                e = exp_q.pop_front();
                check("res_data", res_data, e.data);
                check("res_tag", 32'(res_tag), 32'(e.tag));
                check("res_exc", 32'(res_exc), 32'(e.exc));
            end
            pops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
    endtask

    task automatic wait_res(input int max_cycles);
        int n = 0;
        while (!res_valid && n < max_cycles) begin
            step();
            n++;
        end
        check("res_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        check({name, "_res_valid"}, 32'(res_valid), 32'd0);
        check({name, "_res_data"}, res_data, 32'd0);
        check({name, "_res_tag"}, 32'(res_tag), 32'd0);
        check({name, "_res_exc"}, 32'(res_exc), 32'd0);
        check({name, "_fpu_op"}, 32'(fpu_operation), 32'd0);
        check({name, "_fpu_a"}, fpu_a, 32'd0);
        check({name, "_fpu_b"}, fpu_b, 32'd0);
    endtask

    initial begin
        int p0;
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        res_ready = 1'b0;
        #1;
        check_reset_outputs("por");
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b1;
        #1 check("ready_after_rst", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Single multiply: 20 * 2, tag 3, latency to res_valid is 3 edges.
        drive(2'b10, 32'h41A00000, 32'h40000000, 4'd3);
        step();
        cmd_valid = 1'b0;
        check("lat_t0", 32'(res_valid), 32'd0);
        step(); check("lat_t1", 32'(res_valid), 32'd0);
        step(); check("lat_t2", 32'(res_valid), 32'd0);
        step(); check("lat_t3", 32'(res_valid), 32'd1);
        check("mul_data", res_data, 32'h42200000);
        check("mul_tag", 32'(res_tag), 32'd3);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Back-to-back sub then add, results on consecutive cycles.
        res_ready = 1'b1;
        drive(2'b01, 32'h41900000, 32'h40400000, 4'd1);
        step();
        drive(2'b00, 32'hC1C80000, 32'h41880000, 4'd2);
        step();
        cmd_valid = 1'b0;
        step(); check("b2b_t2_empty", 32'(res_valid), 32'd0);
        step(); check("b2b_first_v", 32'(res_valid), 32'd1);
        check("b2b_first", res_data, 32'h41700000);
        step(); check("b2b_second_v", 32'(res_valid), 32'd1);
        check("b2b_second", res_data, 32'hC1000000);
        step(); check("b2b_done", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Backpressure: only RES_DEPTH commands may issue while results are stuck.
        for (int i = 0; i < 6; i++) begin
            check("bp_ready", 32'(cmd_ready), 32'd1);
            drive(2'b00, 32'h3F800000 + 32'(i), 32'(i), TAG_W'(i));
            step();
        end
        cmd_valid = 1'b0;
        repeat (4) step();
        check("bp_four_issued", fpu_a, 32'h3F800003);
        for (int i = 6; i < 8; i++) begin
            check("bp_ready_late", 32'(cmd_ready), 32'd1);
            drive(2'b00, 32'h3F800000 + 32'(i), 32'(i), TAG_W'(i));
            step();
        end
        cmd_valid = 1'b0;
        check("bp_full", 32'(cmd_ready), 32'd0);
        step();
        check("bp_still_four", fpu_a, 32'h3F800003);
        check("bp_res_valid", 32'(res_valid), 32'd1);
        p0 = pops;
        res_ready = 1'b1;
        for (int n = 0; n < 40 && (pops - p0) < 8; n++) step();
        check("bp_drained", 32'(pops - p0), 32'd8);
        res_ready = 1'b0;

        // Divide by zero.
        drive(2'b11, 32'h41A00000, 32'h00000000, 4'd5);
        step();
        cmd_valid = 1'b0;
        wait_res(10);
`ifdef FPU_ISSUE_DIVZERO_EN
        check("dz_data", res_data, 32'h7FC00000);
        check("dz_exc", 32'(res_exc), 32'd1);
`else
        check("dz_data", res_data, 32'h41A00003);
        check("dz_exc", 32'(res_exc), 32'd0);
`endif
        check("dz_tag", 32'(res_tag), 32'd5);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Reset with work queued and in flight.
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 32'h40000000 + 32'(i), 32'h1, TAG_W'(10 + i));
            step();
        end
        cmd_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid");
        exp_q.delete();
        step(); step();
        rst = 1'b1;
        #1 check("mid_ready_back", 32'(cmd_ready), 32'd1);
        for (int n = 0; n < 5; n++) begin
            step();
            check("mid_no_stale", 32'(res_valid), 32'd0);
        end
        drive(2'b10, 32'h41A00000, 32'h40000000, 4'd9);
        step();
        cmd_valid = 1'b0;
        wait_res(10);
        check("post_rst_tag", 32'(res_tag), 32'd9);
        check("post_rst_data", res_data, 32'h42200000);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Randomized traffic against the reference queue.
        for (int n = 0; n < 800; n++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_a     = $urandom;
            cmd_b     = ($urandom_range(0, 5) == 0) ? ($urandom_range(0, 1) ? 32'h80000000 : 32'h0) : $urandom;
            cmd_tag   = TAG_W'($urandom);
            res_ready = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int n = 0; n < 60 && (exp_q.size() > 0 || res_valid); n++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_res_valid", 32'(res_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
